// File: rtl/reglk_pkg.sv
// Shared types, constants and the byte-mask helper for the register-lock bank.
package reglk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        HOLD  = 2'd2
    } state_e;

    typedef enum logic {
        SRC_SW   = 1'b0,
        SRC_JTAG = 1'b1
    } src_e;

    localparam int REGLK_MASTER_BIT = 0;

    // Sized for the widest supported word; callers cast down to their WIDTH.
    function automatic logic [63:0] byte_mask(input logic [7:0] be);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/reglk_sync_edge.sv
// Two-flop synchroniser for the debug unlock level with a registered rising-edge pulse.
module reglk_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            rise   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], din};
            rise   <= sync_q[0] & ~sync_q[1];
        end
    end

    assign level = sync_q[1];

endmodule

// File: rtl/reglk_bank_ctrl.sv
// Sticky register-lock bank with req/gnt bus port and sweep-based unlock.
// Optional audit outputs (viol_o, viol_cnt_o) are built when REGLK_AUDIT_EN is defined.
//
// state | meaning
// IDLE  | bus port open, waiting for a sweep trigger
// SWEEP | clearing one lock word per cycle, bus blocked
// HOLD  | JTAG sweep done, bus blocked until the unlock level drops
module reglk_bank_ctrl
    import reglk_pkg::*;
#(
    parameter int NUM_WORDS = 6,
    parameter int WIDTH     = 32,
    parameter int AW        = $clog2(NUM_WORDS)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            req_i,
    input  logic                            we_i,
    input  logic [AW-1:0]                   addr_i,
    input  logic [WIDTH-1:0]                wdata_i,
    input  logic [WIDTH/8-1:0]              be_i,
    output logic                            gnt_o,
    output logic                            rvalid_o,
    output logic [WIDTH-1:0]                rdata_o,
    output logic                            err_o,
    input  logic                            jtag_unlock_i,
    input  logic                            rst_reg_lck_i,
    output logic                            busy_o,
`ifdef REGLK_AUDIT_EN
    output logic                            viol_o,
    output logic [7:0]                      viol_cnt_o,
`endif
    output logic [NUM_WORDS-1:0][WIDTH-1:0] reglk_o
);

    state_e state, state_nx;
    src_e   src;
    logic [AW-1:0] idx;
    logic [NUM_WORDS-1:0][WIDTH-1:0] mem;

    logic jtag_level, jtag_rise;
    logic master_lock, sweep_start, in_range, last_idx, wr_ok;
    logic [7:0] be_ext;
    logic [WIDTH-1:0] wmask;

    reglk_sync_edge u_sync (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .din   (jtag_unlock_i),
        .level (jtag_level),
        .rise  (jtag_rise)
    );

    assign master_lock = mem[0][REGLK_MASTER_BIT];
    assign sweep_start = (state == IDLE) & (jtag_rise | (rst_reg_lck_i & ~master_lock));
    assign gnt_o       = req_i & (state == IDLE) & ~sweep_start;
    assign in_range    = ({1'b0, addr_i} < (AW+1)'(NUM_WORDS));
    assign last_idx    = (idx == AW'(NUM_WORDS - 1));
    assign be_ext      = 8'(be_i);
    assign wmask       = WIDTH'(byte_mask(be_ext));
    assign wr_ok       = gnt_o & we_i & in_range & ~master_lock;
    assign busy_o      = (state != IDLE);
    assign reglk_o     = mem;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            idx   <= '0;
            src   <= SRC_SW;
        end else begin
            state <= state_nx;
            if (sweep_start) begin
                idx <= '0;
                src <= jtag_rise ? SRC_JTAG : SRC_SW;
            end else if (state == SWEEP) begin
                idx <= idx + AW'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sweep_start) state_nx = SWEEP;
            SWEEP:   if (last_idx) state_nx = (src == SRC_JTAG) ? HOLD : IDLE;
            HOLD:    if (!jtag_level) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Writes only OR bits in; clearing happens solely through the sweep.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem <= '0;
        end else if (state == SWEEP) begin
            mem[idx] <= '0;
        end else if (wr_ok) begin
            mem[addr_i] <= mem[addr_i] | (wdata_i & wmask);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= gnt_o;
            err_o    <= 1'b0;
            if (gnt_o) begin
                if (!in_range) begin
                    err_o   <= 1'b1;
                    rdata_o <= '0;
                end else if (we_i) begin
                    err_o <= master_lock;
                end else begin
                    rdata_o <= mem[addr_i];
                end
            end
        end
    end

`ifdef REGLK_AUDIT_EN
    logic drop, jtag_done;

    assign drop      = gnt_o & we_i & (master_lock | ~in_range);
    assign jtag_done = (state == SWEEP) & last_idx & (src == SRC_JTAG);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            viol_o     <= 1'b0;
            viol_cnt_o <= '0;
        end else if (jtag_done) begin
            viol_o     <= 1'b0;
            viol_cnt_o <= '0;
        end else if (drop) begin
            viol_o <= 1'b1;
            if (viol_cnt_o != 8'hFF) viol_cnt_o <= viol_cnt_o + 8'd1;
        end
    end
`endif

endmodule

// File: doc/reglk_bank_ctrl.md
Name: reglk_bank_ctrl

Overview:
- Parametrised register-lock bank holding NUM_WORDS lock words of WIDTH bits.
- Lock bits are sticky: software can only set them through a simple req/gnt bus port.
- Bits are cleared only by reset, by an authorised JTAG unlock sweep, or by a software clear request while the bank master lock is open.
- Sits beside the peripheral register file; reglk_o feeds per-register write-enable gating.

Parameters:
- NUM_WORDS, 6, number of lock words (2..64).
- WIDTH, 32, bits per lock word (8..64).
- AW, $clog2(NUM_WORDS), address width (derived; not overridden).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  bus request.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  AW  word index.
- wdata_i  in  WIDTH  bits to set.
- be_i  in  WIDTH/8  byte enables.
- gnt_o  out  1  request accepted this cycle.
- rvalid_o  out  1  response valid, one cycle after grant.
- rdata_o  out  WIDTH  read data.
- err_o  out  1  error response, qualified by rvalid_o.
- jtag_unlock_i  in  1  authorised debug unlock level.
- rst_reg_lck_i  in  1  software clear-request pulse.
- busy_o  out  1  sweep in progress.
- reglk_o  out  NUM_WORDS x WIDTH  lock word contents.

Behaviour:
- Reset: all lock words, rdata_o, rvalid_o, err_o and busy_o are 0; FSM is in IDLE.
- Master lock is mem[0][0]. While it is set:
  - every write to every word is dropped and errors (err_o=1);
  - rst_reg_lck_i is ignored.
- gnt_o = req_i & (state==IDLE) & ~sweep_start, combinational.
- Granted write, in range, master lock clear:
  - mem[addr] <= mem[addr] | (wdata_i & byte_mask(be_i)).
  - Bits can only go 0->1; a 0 in wdata never clears a bit.
- Granted read returns mem[addr] on the next cycle with rvalid_o=1, err_o=0.
- addr_i >= NUM_WORDS: no state change; next cycle rvalid_o=1, err_o=1, rdata_o=0.
- rvalid_o and err_o are single-cycle pulses. rdata_o holds its value until the next read response.
- jtag_unlock_i is synchronised with a 2-flop synchroniser; its rising edge is registered. sweep_start is asserted for one cycle in IDLE on either:
  - a JTAG rising edge; or
  - rst_reg_lck_i=1 with the master lock clear.
- FSM states:
  - IDLE -> SWEEP on sweep_start; idx <= 0.
  - SWEEP: mem[idx] <= 0, one word per cycle. After idx==NUM_WORDS-1, go to HOLD if the sweep was JTAG-initiated, else IDLE.
  - HOLD: writes are still not granted until the synchronised jtag_unlock deasserts, then IDLE.
- busy_o=1 in SWEEP and HOLD. Sweep latency is exactly NUM_WORDS cycles.
- Simultaneous sweep_start and req_i: sweep wins; req_i is not granted that cycle.
- The JTAG edge has priority over rst_reg_lck_i; both cause a single sweep.
- A JTAG edge arriving during SWEEP or HOLD is ignored (no restart).
- Reset mid-sweep: all words go to 0 immediately and the FSM returns to IDLE.
- A read granted in the cycle before a sweep returns pre-sweep data.

Optional Feature:
- Macro: REGLK_AUDIT_EN.
- When defined, adds these outputs:
  - viol_o (1 bit, sticky): set on any write dropped because of the master lock or an out-of-range address.
  - viol_cnt_o (8 bits): saturating count of those events.
- Both are cleared by reset or by a completed JTAG sweep; a software sweep does not clear them.
- When undefined, these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package reglk_pkg holds:
  - the state enum (IDLE, SWEEP, HOLD);
  - the sweep-source enum (SRC_SW, SRC_JTAG);
  - the byte_mask function;
  - the constant REGLK_MASTER_BIT=0.
- One sub-module, reglk_sync_edge: 2-flop synchroniser plus rising-edge detect for jtag_unlock_i.

Test Plan:
- Write word 2 = 0x0000_00F0, then word 2 = 0x0000_000F, be=4'hF -> read word 2 gives 0x0000_00FF; write 0x0 -> read still 0x0000_00FF.
- Set word 0 = 0x1 (master lock), write word 3 = 0xFFFF_FFFF -> err_o=1, word 3 stays 0; rst_reg_lck_i pulse -> busy_o stays 0.
- Master lock set, raise jtag_unlock_i -> busy_o high 6 cycles after the sync edge, all words 0, FSM in HOLD. Drop jtag -> IDLE; next write is granted.
- Read addr 7 with NUM_WORDS=6 -> rvalid_o=1, err_o=1, rdata_o=0, no state change.
- req_i write in the same cycle as sweep_start -> gnt_o=0, sweep runs, write not applied. Assert rst_ni low mid-sweep -> all outputs reset.
- REGLK_AUDIT_EN: three locked writes -> viol_cnt_o=3, viol_o=1. After a JTAG sweep -> both 0. Run 300 violations -> viol_cnt_o saturates at 255.
